// File: rtl/burst_mem_model.sv
// Burst memory slave model: programmable wait states on command acceptance and a fixed read latency.
// Define BURST_MEM_MODEL_RANDOM_WAIT_EN to add LFSR-driven extra wait states.
module burst_mem_model #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 4096,
  parameter int BURST_WIDTH  = 8,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rest,
  input  logic [31:0]             s0_address,
  input  logic [DATA_WIDTH/8-1:0] s0_byteEnable,
  input  logic                    s0_read,
  output logic [DATA_WIDTH-1:0]   s0_readData,
  input  logic                    s0_write,
  input  logic [DATA_WIDTH-1:0]   s0_writeData,
  output logic                    s0_waitRequest,
  output logic                    s0_readDataValid,
  input  logic                    s0_beginBurstTransfer,
  input  logic [BURST_WIDTH-1:0]  s0_burstCount
);
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int ADDR_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int BYTE_SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_e;
  state_e state, stateNext;

  logic [ADDR_W-1:0]      cmdAddr, curAddr, issueAddr, wrAddr;
  logic [BURST_WIDTH-1:0] cmdBeats, beatsLeft;
  logic [3:0]             waitCnt;
  logic                   cmd, waitDone, idleAccept, randWait;
  logic                   issueValid, wrBeat, waitReq;
  logic                   unusedInputs;

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0]   memRd;
  logic [READ_LATENCY-1:0] pipeValid;
  logic [DATA_WIDTH-1:0]   pipeData [READ_LATENCY];

  assign unusedInputs = ^{s0_beginBurstTransfer, s0_address};

  // Upper address bits beyond the memory depth are dropped, giving the modulo wrap.
  assign cmdAddr    = ADDR_W'(s0_address >> BYTE_SHIFT);
  assign cmdBeats   = (s0_burstCount == '0) ? BURST_WIDTH'(1) : s0_burstCount;
  assign cmd        = s0_read | s0_write;
  assign waitDone   = (waitCnt == 4'(WAIT_CYCLES));
  assign idleAccept = (state == IDLE) & cmd & waitDone & ~randWait;

`ifdef BURST_MEM_MODEL_RANDOM_WAIT_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign randWait = lfsr[0];
`else
  assign randWait = 1'b0;
`endif

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (idleAccept && cmdBeats != BURST_WIDTH'(1))
                  stateNext = s0_write ? WR_BURST : RD_BURST;
      RD_BURST: if (beatsLeft == BURST_WIDTH'(1)) stateNext = IDLE;
      WR_BURST: if (wrBeat && beatsLeft == BURST_WIDTH'(1)) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Write wins over a simultaneous read in IDLE; reads are ignored inside a write burst.
  always_comb begin
    waitReq    = 1'b1;
    issueValid = 1'b0;
    wrBeat     = 1'b0;
    issueAddr  = curAddr;
    wrAddr     = curAddr;
    case (state)
      IDLE: begin
        waitReq    = (cmd & ~idleAccept) | randWait;
        issueValid = idleAccept & ~s0_write;
        wrBeat     = idleAccept & s0_write;
        issueAddr  = cmdAddr;
        wrAddr     = cmdAddr;
      end
      RD_BURST: begin
        waitReq    = 1'b1;
        issueValid = 1'b1;
      end
      WR_BURST: begin
        waitReq = randWait;
        wrBeat  = s0_write & ~randWait;
      end
      default: waitReq = 1'b1;
    endcase
  end

  assign s0_waitRequest = waitReq | ~rest;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      waitCnt   <= '0;
      curAddr   <= '0;
      beatsLeft <= '0;
    end else begin
      if (state != IDLE || !cmd || idleAccept) waitCnt <= '0;
      else if (!waitDone)                      waitCnt <= waitCnt + 4'd1;
      if (idleAccept) begin
        curAddr   <= cmdAddr + ADDR_W'(1);
        beatsLeft <= cmdBeats - BURST_WIDTH'(1);
      end else if (issueValid || wrBeat) begin
        curAddr   <= curAddr + ADDR_W'(1);
        beatsLeft <= beatsLeft - BURST_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrBeat && rest) begin
      for (int b = 0; b < BYTES; b++)
        if (s0_byteEnable[b]) mem[wrAddr][b*8 +: 8] <= s0_writeData[b*8 +: 8];
    end
  end

  assign memRd = mem[issueAddr];

  // The last pipeline stage only loads on a valid beat so readData holds between beats.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      pipeValid <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipeData[k] <= '0;
    end else begin
      pipeValid[0] <= issueValid;
      if (READ_LATENCY > 1 || issueValid) pipeData[0] <= memRd;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipeValid[k] <= pipeValid[k-1];
        if (k < READ_LATENCY - 1 || pipeValid[k-1]) pipeData[k] <= pipeData[k-1];
      end
    end
  end

  assign s0_readDataValid = pipeValid[READ_LATENCY-1];
  assign s0_readData      = pipeData[READ_LATENCY-1];
endmodule

// File: doc/burst_mem_model.md
BURST_MEM_MODEL -- requirements
Module: burst_mem_model

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- DATA_WIDTH, 32, data bus width in bits (multiple of 8).
- DEPTH_WORDS, 4096, memory depth in words (power of 2).
- BURST_WIDTH, 8, width of the burst count.
- WAIT_CYCLES, 1, waitRequest cycles before each command is accepted (0..15).
- READ_LATENCY, 2, cycles from read acceptance to the first readDataValid (1..8).
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rest, in, 1, asynchronous active-low reset.
- s0_address, in, 32, byte address.
- s0_byteEnable, in, DATA_WIDTH/8, write byte lanes.
- s0_read, in, 1, read command.
- s0_readData, out, DATA_WIDTH, read beat data.
- s0_write, in, 1, write command or beat.
- s0_writeData, in, DATA_WIDTH, write beat data.
- s0_waitRequest, out, 1, command or beat not accepted this cycle.
- s0_readDataValid, out, 1, s0_readData valid.
- s0_beginBurstTransfer, in, 1, marks the first cycle of a burst (informational).
- s0_burstCount, in, BURST_WIDTH, beats in the burst; sampled at command acceptance.

Function
REQ-003 Word index SHALL be s0_address divided by DATA_WIDTH/8, modulo DEPTH_WORDS; burst addresses SHALL increment by one word and wrap from DEPTH_WORDS-1 to 0.
REQ-004 A burstCount of 0 SHALL be treated as 1.
REQ-005 States SHALL be IDLE, RD_BURST and WR_BURST.
REQ-006 In IDLE with s0_read or s0_write high, s0_waitRequest SHALL be high until the command has been held for WAIT_CYCLES cycles, then low for one cycle (the acceptance cycle).
REQ-007 In IDLE with no command, s0_waitRequest SHALL be low.
REQ-008 The wait counter SHALL clear on acceptance or when the command drops.
REQ-009 When s0_read and s0_write are high together in IDLE, the write SHALL take priority and the read SHALL be ignored.
REQ-010 An accepted read of N beats SHALL enter RD_BURST, issue one word address per cycle for N cycles starting with the acceptance cycle, and hold s0_waitRequest high for the N-1 cycles after acceptance.
REQ-011 A read burst SHALL return to IDLE after the last address is issued.
REQ-012 Read beats SHALL appear on s0_readData with s0_readDataValid high exactly READ_LATENCY cycles after their issue, as consecutive cycles without gaps.
REQ-013 A new command SHALL be acceptable while earlier read beats are still draining from the latency pipeline.
REQ-014 An accepted write SHALL store beat 0 on the acceptance cycle, and SHALL enter WR_BURST if N>1.
REQ-015 In WR_BURST, each cycle with s0_write high SHALL be accepted with s0_waitRequest low and store the next beat; cycles with s0_write low SHALL be idle with no beat consumed.
REQ-016 After the Nth write beat, the block SHALL return to IDLE.
REQ-017 Writes SHALL update only the bytes whose s0_byteEnable bit is high.
REQ-018 In WR_BURST, s0_read SHALL be ignored and s0_burstCount on later beats SHALL be ignored.
REQ-019 A read of a word written in an earlier cycle SHALL return the written data, with no read-during-write hazard across bursts.
REQ-020 s0_readData SHALL hold its last value when s0_readDataValid is low.

Reset
REQ-021 While rest is low: s0_waitRequest SHALL be 1, s0_readDataValid 0, s0_readData 0, state IDLE, counters and the latency pipeline cleared.
REQ-022 Memory contents SHALL NOT be reset.
REQ-023 Asserting rest mid-burst SHALL abort the burst immediately and SHALL drop all pending read beats.
REQ-024 On the first clk edge after rest deasserts, s0_waitRequest SHALL follow REQ-006 and REQ-007.

Configuration
REQ-025 With macro BURST_MEM_MODEL_RANDOM_WAIT_EN defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset; advancing every cycle) SHALL additionally force s0_waitRequest high in IDLE and WR_BURST on any cycle where lfsr[0]==1.
REQ-026 Without BURST_MEM_MODEL_RANDOM_WAIT_EN, wait states SHALL come from WAIT_CYCLES only, and the LFSR SHALL not exist.

Verification
REQ-027 Reset: hold rest low 100 ns -> s0_waitRequest=1 and s0_readDataValid=0 throughout; after release with no command, s0_waitRequest=0 within 1 cycle.
REQ-028 Single write then read: write address 8, byteEnable 4'hf, data 32'h12345678, then read address 8 -> exactly one valid beat of 32'h12345678, first valid READ_LATENCY cycles after acceptance.
REQ-029 Byte enable: write 32'hFFFFFFFF to address 16, then 32'h00000000 with byteEnable 4'h5 -> read of address 16 returns 32'hFF00FF00.
REQ-030 Write burst of 8 beats at address 2048 with data 32'h100..32'h107 and s0_write gaps on beats 3 and 5, then read burst of 8 -> eight consecutive valid beats 32'h100..32'h107, with s0_waitRequest high for 7 cycles after read acceptance.
REQ-031 Wrap: with DEPTH_WORDS=4096, write a 4-beat burst at byte address 16376 -> words 4094, 4095, 0 and 1 are written, confirmed by single reads of each.
REQ-032 Reset mid read burst of 16 at beat 5 -> s0_readDataValid falls to 0 immediately and no further beats are returned after release.
